convolution3: RTL and testbench
===============================

CONVOLUTION3 -- requirements
Module: convolution3

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the unsigned bit width of each data and kernel element; the SHALL support range is 2..16.
REQ-002 Port i_clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port i_rst_n, input, 1 bit, is the reset; it SHALL be synchronous and active-low.
REQ-004 Port i_data, input, 3x3 unpacked array of DATA_WIDTH-bit elements, indexed [row 0..2][col 0..2], is the image window.
REQ-005 Port i_kernel, input, 3x3 unpacked array of DATA_WIDTH-bit elements, indexed [row 0..2][col 0..2], holds the weights.
REQ-006 Port i_cumulative_sum, input, 3*DATA_WIDTH bits, is a partial sum added to the window result (channel accumulation).
REQ-007 Port o_result, output, 3*DATA_WIDTH bits, is the registered convolution result.

Function
REQ-008 All arithmetic SHALL be unsigned.
REQ-009 The block SHALL compute o_result = i_cumulative_sum + sum over r,c of i_data[r][c]*i_kernel[r][c], element-wise with matching indices and no kernel flip.
REQ-010 Each product SHALL be held at full 2*DATA_WIDTH width; the adder tree SHALL be wide enough that no intermediate sum loses bits.
REQ-011 The final sum SHALL be truncated modulo 2^(3*DATA_WIDTH) to the output width when CONV3_SATURATE_EN is undefined.
REQ-012 The pipeline SHALL have two register stages:
- stage 1 registers the nine products and i_cumulative_sum;
- stage 2 registers the adder-tree sum into o_result.
REQ-013 Inputs sampled at rising edge N SHALL appear on o_result immediately after rising edge N+1, giving a latency of 2 edges.
REQ-014 The block SHALL accept a new input set every cycle (throughput 1/cycle), with no handshake and no stall.
REQ-015 o_result SHALL change only on clock edges; combinational paths from any input to o_result are prohibited.

Reset
REQ-016 While i_rst_n is low at a rising edge, all stage-1 registers and o_result SHALL be cleared to 0.
REQ-017 When reset is asserted mid-stream, in-flight data SHALL be discarded and o_result SHALL read 0 after that edge.
REQ-018 On the first edge with i_rst_n high, stage 1 SHALL capture the inputs; o_result SHALL reflect them after the second such edge.

Configuration
REQ-019 Macro CONV3_SATURATE_EN, when defined, SHALL make o_result clamp to 2^(3*DATA_WIDTH)-1 if the full-precision sum exceeds that value.
REQ-020 When CONV3_SATURATE_EN is undefined, overflow SHALL wrap per REQ-011.
REQ-021 Both builds SHALL produce identical results for every non-overflowing input.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (DATA_WIDTH=4):
- Reset held low for 2 edges -> o_result=0 throughout.
- data rows {1,2,3},{4,5,6},{7,8,9}; kernel rows {1,2,3},{4,1,1},{1,1,1}; cumulative_sum=0 -> o_result=65 two edges after release, stable while inputs are held.
- Same data and kernel, cumulative_sum=100 -> o_result=165.
- All data and kernel=15, cumulative_sum=4095 -> 6120 full precision; o_result=2024 (wrap) without the macro, 4095 with CONV3_SATURATE_EN.
- Back-to-back input sets A (expected 65) then B (all ones, cumulative_sum=0, expected 9) on consecutive edges -> o_result shows 65 then 9 on consecutive cycles.
- i_rst_n pulsed low for one edge while data is streaming -> o_result=0 after that edge, then valid results resume after 2 edges.

Source files
------------

// File: rtl/convolution3.sv
// convolution3 -- two-stage pipelined 3x3 multiply-accumulate window.
//
// o_result = i_cumulative_sum + sum(i_data[r][c] * i_kernel[r][c]), unsigned,
// with no kernel flip. One input set is accepted per clock. The result
// appears two rising edges after its inputs are sampled.
//
// Ports
//   i_clk            : clock, rising edge
//   i_rst_n          : synchronous active-low reset; clears both stages
//   i_data[3][3]     : image window, DATA_WIDTH unsigned per element
//   i_kernel[3][3]   : weights, DATA_WIDTH unsigned per element
//   i_cumulative_sum : 3*DATA_WIDTH partial sum from a previous channel
//   o_result         : 3*DATA_WIDTH registered result
//
// Build option
//   CONV3_SATURATE_EN : when defined, an oversized sum clamps to all-ones.
//                       When undefined, the sum wraps modulo 2^(3*DATA_WIDTH).

// Single element multiplier. Operands are zero-extended first, so the
// product is computed at its full 2*W width.
module conv3_mul #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
endmodule

module convolution3 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   i_data   [3][3],
  input  logic [DATA_WIDTH-1:0]   i_kernel [3][3],
  input  logic [3*DATA_WIDTH-1:0] i_cumulative_sum,
  output logic [3*DATA_WIDTH-1:0] o_result
);
  localparam int N_TAPS = 9;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int OUT_W  = 3 * DATA_WIDTH;
  // Nine full-scale products plus a full-scale partial sum need at most
  // OUT_W+2 bits at small widths; four spare bits covers the whole range.
  localparam int SUM_W  = OUT_W + 4;

  // Stage 1: products and partial sum
  logic [PROD_W-1:0] prod_d [N_TAPS];
  logic [PROD_W-1:0] prod_q [N_TAPS];
  logic [OUT_W-1:0]  cum_d;
  logic [OUT_W-1:0]  cum_q;

  // Stage 2: reduced sum
  logic [SUM_W-1:0]  sum_full;
  logic [OUT_W-1:0]  result_d;
  logic [OUT_W-1:0]  result_q;

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      conv3_mul #(.W(DATA_WIDTH)) u_mul (
        .a (i_data[r][c]),
        .b (i_kernel[r][c]),
        .p (prod_d[r*3+c])
      );
    end
  end

  always_comb begin
    cum_d = i_cumulative_sum;
  end

  always_comb begin
    sum_full = {{(SUM_W-OUT_W){1'b0}}, cum_q};
    for (int i = 0; i < N_TAPS; i++) begin
      sum_full = sum_full + {{(SUM_W-PROD_W){1'b0}}, prod_q[i]};
    end
`ifdef CONV3_SATURATE_EN
    if (|sum_full[SUM_W-1:OUT_W]) result_d = {OUT_W{1'b1}};
    else                          result_d = sum_full[OUT_W-1:0];
`else
    result_d = OUT_W'(sum_full);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_TAPS; i++) prod_q[i] <= '0;
      cum_q    <= '0;
      result_q <= '0;
    end else begin
      for (int i = 0; i < N_TAPS; i++) prod_q[i] <= prod_d[i];
      cum_q    <= cum_d;
      result_q <= result_d;
    end
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_convolution3.sv
// Self-checking bench for convolution3 at DATA_WIDTH=4. Directed scenarios
// followed by randomized streaming with occasional reset pulses; every
// cycle's output is compared against a reference computed from the
// arithmetic definition of the result.
module tb_convolution3;
  localparam int DW = 4;
  localparam int OW = 3 * DW;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [DW-1:0] i_data   [3][3];
  logic [DW-1:0] i_kernel [3][3];
  logic [OW-1:0] i_cumulative_sum;
  logic [OW-1:0] o_result;

  int tests = 0;
  int fails = 0;

  // Reference history: the value the inputs of the previous edge imply,
  // and whether reset was released at that edge.
  longint last_f   = 0;
  bit     last_rst = 1'b0;

  convolution3 #(.DATA_WIDTH(DW)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_data           (i_data),
    .i_kernel         (i_kernel),
    .i_cumulative_sum (i_cumulative_sum),
    .o_result         (o_result)
  );

  always #5 i_clk = ~i_clk;

  // Expected output for the current input set, from plain arithmetic.
  function automatic longint model();
    longint full, lim;
    full = longint'(i_cumulative_sum);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        full += longint'(i_data[r][c]) * longint'(i_kernel[r][c]);
    lim = longint'(1) << OW;
`ifdef CONV3_SATURATE_EN
    if (full >= lim) full = lim - 1;
`else
    full = full % lim;
`endif
    return full;
  endfunction

  task automatic check(input string tag, input longint exp);
    tests++;
    assert (longint'(o_result) === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, o_result, exp);
    end
  endtask

  // One rising edge. Output after edge k equals the model of the inputs
  // at edge k-1, provided reset was high at both edges; otherwise 0.
  task automatic tick(input string tag);
    longint cur_f;
    bit     cur_rst;
    longint exp;
    cur_f   = model();
    cur_rst = i_rst_n;
    @(posedge i_clk);
    #1;
    exp = (cur_rst && last_rst) ? last_f : 0;
    check(tag, exp);
    last_f   = cur_f;
    last_rst = cur_rst;
  endtask

  task automatic set_a(input int cum);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        i_data[r][c] = DW'(r*3 + c + 1);
    i_kernel[0][0] = 1; i_kernel[0][1] = 2; i_kernel[0][2] = 3;
    i_kernel[1][0] = 4; i_kernel[1][1] = 1; i_kernel[1][2] = 1;
    i_kernel[2][0] = 1; i_kernel[2][1] = 1; i_kernel[2][2] = 1;
    i_cumulative_sum = OW'(cum);
  endtask

  task automatic set_fill(input int d, input int k, input int cum);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        i_data[r][c]   = DW'(d);
        i_kernel[r][c] = DW'(k);
      end
    i_cumulative_sum = OW'(cum);
  endtask

  task automatic set_rand();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        i_data[r][c]   = DW'($urandom);
        i_kernel[r][c] = DW'($urandom);
      end
    i_cumulative_sum = OW'($urandom);
  endtask

  initial begin
    // Reset held for two edges with arbitrary inputs present
    i_rst_n = 1'b0;
    set_rand();
    tick("reset0");
    check("reset0_zero", 0);
    tick("reset1");
    check("reset1_zero", 0);

    // Set A, cumulative 0 -> 65 two edges after release, then held
    set_a(0);
    i_rst_n = 1'b1;
    tick("a_edge1");
    tick("a_edge2");
    check("a_65", 65);
    tick("a_hold1");
    check("a_hold_65", 65);
    tick("a_hold2");

    // Same window, cumulative 100 -> 165
    set_a(100);
    tick("a100_edge1");
    tick("a100_edge2");
    check("a100_165", 165);

    // Full-scale inputs: 6120 wraps to 2024 or clamps to 4095
    set_fill(15, 15, 4095);
    tick("max_edge1");
    tick("max_edge2");
`ifdef CONV3_SATURATE_EN
    check("max_sat", 4095);
`else
    check("max_wrap", 2024);
`endif

    // Back-to-back A then B
    set_a(0);
    tick("b2b_a");
    set_fill(1, 1, 0);
    tick("b2b_b");
    check("b2b_65", 65);
    tick("b2b_next");
    check("b2b_9", 9);

    // Streaming with a single-edge reset pulse
    for (int i = 0; i < 4; i++) begin
      set_rand();
      tick("stream_pre");
    end
    set_rand();
    i_rst_n = 1'b0;
    tick("pulse");
    check("pulse_zero", 0);
    i_rst_n = 1'b1;
    set_a(0);
    tick("resume1");
    check("resume1_zero", 0);
    set_rand();
    tick("resume2");
    check("resume2_65", 65);

    // Randomized streaming, occasional reset
    for (int i = 0; i < 300; i++) begin
      set_rand();
      i_rst_n = ($urandom_range(0, 19) != 0);
      tick("rand");
    end

    // Boundary: saturate/wrap edge exactly at full scale (no overflow)
    i_rst_n = 1'b1;
    set_fill(0, 15, 4095);
    tick("edge1");
    tick("edge2");
    check("edge_4095", 4095);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
